// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and sizing helpers for the serial adder sequencer
package serial_adder_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_adder_bit_cnt.sv
// rtl/serial_adder_bit_cnt.sv - bit-position counter with clear, enable and terminal-count flag
module serial_adder_bit_cnt #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o,
  output logic             tc_o
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      r_count <= '0;
    end else if (en_i) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count_o = r_count;
  assign tc_o    = (r_count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - load/shift sequencer for a bit-serial adder; SERIAL_ADDER_CTRL_ABORT_EN adds abort_i
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
`ifdef SERIAL_ADDER_CTRL_ABORT_EN
  input  logic             abort_i,
`endif
  input  logic             start_i,
  output logic             ready_o,
  output logic             load_o,
  output logic             carry_clr_o,
  output logic             shift_en_o,
  input  logic             carry_i,
  output logic [CNT_W-1:0] bit_idx_o,
  output logic             busy_o,
  output logic             result_valid_o,
  input  logic             result_ready_i,
  output logic             cout_o
);

  state_t           r_state;
  state_t           w_next;
  logic             r_cout;
  logic             w_cnt_clr;
  logic             w_cnt_en;
  logic             w_tc;
  logic             w_abort;
  logic             w_run;
  logic [CNT_W-1:0] w_count;

`ifdef SERIAL_ADDER_CTRL_ABORT_EN
  assign w_abort = abort_i;
`else
  assign w_abort = 1'b0;
`endif

  serial_adder_bit_cnt #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bit_cnt (
    .clk_i   (clk_i),
    .rst_i   (reset_n_i),
    .clr_i   (w_cnt_clr),
    .en_i    (w_cnt_en),
    .count_o (w_count),
    .tc_o    (w_tc)
  );

  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      r_state <= IDLE;
      r_cout  <= 1'b0;
    end else begin
      r_state <= w_next;
      // An aborted final shift must leave the previous carry-out in place.
      if (r_state == SHIFT && w_tc && !w_abort) begin
        r_cout <= carry_i;
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    w_cnt_clr = 1'b0;
    w_cnt_en  = 1'b0;
    case (r_state)
      IDLE:  if (start_i) w_next = LOAD;
      LOAD: begin
        w_cnt_clr = 1'b1;
        w_next    = w_abort ? IDLE : SHIFT;
      end
      SHIFT: begin
        if (w_abort) begin
          w_cnt_clr = 1'b1;
          w_next    = IDLE;
        end else if (w_tc) begin
          w_cnt_clr = 1'b1;
          w_next    = DONE;
        end else begin
          w_cnt_en  = 1'b1;
        end
      end
      DONE:  if (result_ready_i) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Reset is asserted high, so every strobe is masked while it is held.
  assign w_run          = !reset_n_i;
  assign ready_o        = (r_state == IDLE)  && w_run;
  assign load_o         = (r_state == LOAD)  && w_run;
  assign carry_clr_o    = (r_state == LOAD)  && w_run;
  assign shift_en_o     = (r_state == SHIFT) && w_run;
  assign result_valid_o = (r_state == DONE)  && w_run;
  assign busy_o         = (r_state != IDLE)  && w_run;
  assign bit_idx_o      = shift_en_o ? w_count : '0;
  assign cout_o         = r_cout;

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Sequencer for the bit-serial adder datapath: two PISO operand shift registers, a full adder with carry flip-flop, and the serial-to-parallel result collector.
- Accepts an add request through a valid/ready handshake, then issues load, carry-clear and exactly WIDTH shift-enable cycles.
- Captures the final carry-out and presents result-valid until the consumer accepts it.
- Sits between the operand source and the serial datapath; one block per serial adder.

Parameters:
- WIDTH, 8, operand/result width in bits (≥1); also the number of shift cycles per operation.
- CNT_W, $clog2(WIDTH+1), bit-counter width (derived; do not override).

Ports:
- clk_i  input  1  clock; all logic on posedge.
- reset_n_i  input  1  reset, synchronous, active-high (asserted = 1) despite the _n suffix.
- start_i  input  1  request valid; operands are already presented to the PISO parallel inputs.
- ready_o  output  1  controller idle; a request is accepted when start_i && ready_o at a posedge.
- load_o  output  1  one-cycle parallel load strobe to both operand PISOs.
- carry_clr_o  output  1  one-cycle clear to the carry flip-flop; coincident with load_o.
- shift_en_o  output  1  shift enable to the PISOs, carry flip-flop and serial-to-parallel collector.
- carry_i  input  1  combinational full-adder carry-out of the current bit.
- bit_idx_o  output  CNT_W  index of the bit being added (0 = LSB); valid while shift_en_o = 1.
- busy_o  output  1  high in LOAD, SHIFT and DONE.
- result_valid_o  output  1  sum is complete in the collector; cout_o is valid.
- result_ready_i  input  1  consumer accepts the result.
- cout_o  output  1  final carry-out (overflow) of the add.

Behaviour:
- FSM states IDLE, LOAD, SHIFT, DONE. Reset and default state is IDLE.
- Reset values: load_o, carry_clr_o, shift_en_o, result_valid_o, busy_o, cout_o = 0; bit_idx_o = 0.
- ready_o = (state==IDLE) && !reset_n_i.
- IDLE: ready_o = 1. On start_i, go to LOAD. start_i is ignored in every other state, with no queuing.
- LOAD: load_o = 1 and carry_clr_o = 1 for exactly one cycle; counter <= 0; go to SHIFT.
- SHIFT: shift_en_o = 1 and bit_idx_o = counter; counter increments each cycle.
  - When counter == WIDTH-1: cout_o <= carry_i, counter <= 0, go to DONE.
  - shift_en_o is high for exactly WIDTH consecutive cycles.
- DONE: result_valid_o = 1, held stable (with cout_o) until result_ready_i.
  - On result_ready_i, go to IDLE. result_valid_o falls the cycle after the handshake.
  - If result_ready_i is already high on DONE entry, DONE lasts one cycle.
- Latency: accept edge at cycle N; load_o in N+1; shift_en_o in N+2..N+1+WIDTH; result_valid_o from N+2+WIDTH.
- Minimum back-to-back period: WIDTH+3 cycles.
- cout_o holds its value until the next op's final shift.
- WIDTH = 1: a single SHIFT cycle, which is also the capture cycle.
- Reset mid-operation (any state): at that edge go to IDLE, zero all outputs and counter, and discard the in-flight result. No result_valid_o for it.
- Counter never exceeds WIDTH-1, so there is no wrap-around.
- load_o, carry_clr_o and shift_en_o are mutually exclusive except load_o with carry_clr_o.

Optional Feature:
- Macro SERIAL_ADDER_CTRL_ABORT_EN.
- Defined: adds port abort_i (input, 1).
  - abort_i high in LOAD or SHIFT: next state is IDLE, shift_en_o drops next cycle, counter <= 0, cout_o unchanged, no result_valid_o.
  - abort_i is ignored in IDLE and DONE.
- Undefined: no abort_i port; an operation always runs to DONE.

Decomposition:
- Package serial_adder_pkg:
  - WIDTH default.
  - state typedef: enum logic [1:0] {IDLE, LOAD, SHIFT, DONE}.
  - function for the CNT_W calculation.
- Sub-module serial_adder_bit_cnt: clear/enable counter with terminal-count flag (count == WIDTH-1). The FSM stays in serial_adder_ctrl.

Test Plan:
- Reset held 3 cycles, then released:
  - During reset, ready_o = 0 and all outputs = 0.
  - Cycle after release, ready_o = 1.
- WIDTH=8, one-cycle start_i, result_ready_i tied 1:
  - load_o and carry_clr_o for exactly 1 cycle.
  - shift_en_o for 8 cycles with bit_idx_o 0..7.
  - result_valid_o for 1 cycle at accept+10.
- Datapath model with A=0xB5, B=0x6E:
  - Collector = 0x23, cout_o = 1.
  - Then A=0x0F, B=0x01: sum 0x10, cout_o = 0.
- result_ready_i held 0 for 5 DONE cycles:
  - result_valid_o and cout_o stable.
  - start_i pulses ignored (no load_o).
  - Raise result_ready_i: IDLE next cycle.
- reset_n_i pulsed at SHIFT bit_idx_o = 4:
  - IDLE next cycle, no result_valid_o.
  - A new request completes normally with 8 shifts.
- With SERIAL_ADDER_CTRL_ABORT_EN, abort_i at bit_idx_o = 2:
  - shift_en_o count = 3, no result_valid_o, ready_o = 1 next cycle.
  - Rerun with WIDTH=1: 1 shift, valid at accept+3.
